// File: rtl/sparse_arithmetic_pkg.sv
// Shared types for the sparse block sequencer: FSM state encoding and index-width helper.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package sparse_arithmetic_pkg;

  // IDLE: waiting for an input frame; EMIT: streaming compacted beats of the held frame.
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    EMIT = 1'b1
  } seq_state_e;

  // Width of a block index. A single-block configuration still gets a 1-bit field.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sparse_block_pick.sv
// Picks the lowest-indexed remaining non-zero blocks (up to OUT_BLOCK_NUM) from a zero mask.
// Latency: purely combinational.
// Backpressure: none; the caller decides when to commit mask_o.
// Ports: mask_i  - remaining mask (1 = block zero or already emitted)
//        idx_o   - selected block index per output slot, ascending; unused slots read 0
//        count_o - number of filled slots
//        mask_o  - mask_i with the selected blocks marked as done
module sparse_block_pick
  import sparse_arithmetic_pkg::*;
#(
  parameter int IN_BLOCK_NUM  = 4,
  parameter int OUT_BLOCK_NUM = 2,
  localparam int IDX_W = idx_width(IN_BLOCK_NUM),
  localparam int CNT_W = $clog2(OUT_BLOCK_NUM + 1)
) (
  input  logic [IN_BLOCK_NUM-1:0]              mask_i,
  output logic [OUT_BLOCK_NUM-1:0][IDX_W-1:0]  idx_o,
  output logic [CNT_W-1:0]                     count_o,
  output logic [IN_BLOCK_NUM-1:0]              mask_o
);

  // rank counts the non-zero blocks seen below block b; a block whose rank is a
  // valid slot number lands in that slot, so slots fill in ascending block order.
  always_comb begin
    int rank;
    rank    = 0;
    idx_o   = '0;
    mask_o  = mask_i;
    for (int b = 0; b < IN_BLOCK_NUM; b++) begin
      if (!mask_i[b]) begin
        for (int s = 0; s < OUT_BLOCK_NUM; s++) begin
          if (rank == s) begin
            idx_o[s]  = IDX_W'(b);
            mask_o[b] = 1'b1;
          end
        end
        rank = rank + 1;
      end
    end
    count_o = CNT_W'((rank > OUT_BLOCK_NUM) ? OUT_BLOCK_NUM : rank);
  end

endmodule

// File: rtl/sparse_block_sequencer.sv
// Registers one frame of blocks and emits its non-zero blocks compacted, OUT_BLOCK_NUM per beat.
// Latency: first output beat is valid the cycle after input acceptance.
// Backpressure: outputs hold while data_out_ready=0; input is refused for the whole frame.
// Ports: clk/rst (sync, active-high); data_in/data_in_zero_mask with data_in_valid/data_in_ready;
//        data_out/data_out_count/data_out_last with data_out_valid/data_out_ready.
// OUT_BLOCK_NUM must satisfy 1 <= OUT_BLOCK_NUM <= IN_BLOCK_NUM.
module sparse_block_sequencer
  import sparse_arithmetic_pkg::*;
#(
  parameter int IN_BLOCK_NUM  = 4,
  parameter int BLOCK_SIZE    = 4,
  parameter int OUT_BLOCK_NUM = 2,
  parameter int IN_WIDTH      = 16
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [IN_WIDTH-1:0]                  data_in [IN_BLOCK_NUM*BLOCK_SIZE],
  input  logic [IN_BLOCK_NUM-1:0]              data_in_zero_mask,
  input  logic                                 data_in_valid,
  output logic                                 data_in_ready,
  output logic [IN_WIDTH-1:0]                  data_out [OUT_BLOCK_NUM*BLOCK_SIZE],
  output logic [$clog2(OUT_BLOCK_NUM+1)-1:0]   data_out_count,
  output logic                                 data_out_last,
  output logic                                 data_out_valid,
  input  logic                                 data_out_ready
);

  localparam int NUM_IN_EL = IN_BLOCK_NUM * BLOCK_SIZE;
  localparam int IDX_W     = idx_width(IN_BLOCK_NUM);
  localparam int CNT_W     = $clog2(OUT_BLOCK_NUM + 1);

  seq_state_e                          state_q, state_d;
  logic [IN_BLOCK_NUM-1:0]             mask_q, mask_d;
  logic [IN_WIDTH-1:0]                 data_q [NUM_IN_EL];
  logic [IN_WIDTH-1:0]                 data_d [NUM_IN_EL];

  logic [OUT_BLOCK_NUM-1:0][IDX_W-1:0] pick_idx;
  logic [CNT_W-1:0]                    pick_cnt;
  logic [IN_BLOCK_NUM-1:0]             pick_mask;
  logic                                emit, in_fire, out_fire, beat_last;

  sparse_block_pick #(
    .IN_BLOCK_NUM  (IN_BLOCK_NUM),
    .OUT_BLOCK_NUM (OUT_BLOCK_NUM)
  ) u_pick (
    .mask_i  (mask_q),
    .idx_o   (pick_idx),
    .count_o (pick_cnt),
    .mask_o  (pick_mask)
  );

  assign emit      = (state_q == EMIT);
  assign in_fire   = data_in_valid && data_in_ready;
  assign out_fire  = emit && data_out_ready;
  // Nothing left once this beat's picks are retired.
  assign beat_last = &pick_mask;

  assign data_in_ready  = (state_q == IDLE);
  assign data_out_valid = emit;
  assign data_out_count = emit ? pick_cnt : '0;
  assign data_out_last  = emit && beat_last;

  // Outputs are decoded from registered state only, so they cannot move while stalled.
  always_comb begin
    for (int s = 0; s < OUT_BLOCK_NUM; s++) begin
      for (int e = 0; e < BLOCK_SIZE; e++) begin
        data_out[s*BLOCK_SIZE+e] = '0;
        if (emit && (CNT_W'(s) < pick_cnt)) begin
          for (int b = 0; b < IN_BLOCK_NUM; b++) begin
            if (pick_idx[s] == IDX_W'(b)) data_out[s*BLOCK_SIZE+e] = data_q[b*BLOCK_SIZE+e];
          end
        end
      end
    end
  end

  // in_fire only happens in IDLE and out_fire only in EMIT, so the branches never collide.
  // Retiring the last beat leaves the mask all ones, which is also its idle value.
  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    data_d  = data_q;
    if (in_fire) begin
      data_d  = data_in;
      mask_d  = data_in_zero_mask;
      state_d = EMIT;
    end else if (out_fire) begin
      mask_d = pick_mask;
      if (beat_last) state_d = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      mask_q  <= '1;
      for (int i = 0; i < NUM_IN_EL; i++) data_q[i] <= '0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: tb/tb_sparse_block_sequencer.sv
module tb_sparse_block_sequencer;

  localparam int IN_BN  = 4;
  localparam int BS     = 4;
  localparam int OUT_BN = 2;
  localparam int W      = 16;
  localparam int NI     = IN_BN * BS;
  localparam int NO     = OUT_BN * BS;

  typedef logic [NO-1:0][W-1:0] beat_t;

  logic             clk = 1'b0;
  logic             rst;
  logic [W-1:0]     data_in [NI];
  logic [IN_BN-1:0] data_in_zero_mask;
  logic             data_in_valid;
  logic             data_in_ready;
  logic [W-1:0]     data_out [NO];
  logic [1:0]       data_out_count;
  logic             data_out_last;
  logic             data_out_valid;
  logic             data_out_ready;

  int    tests = 0;
  int    fails = 0;
  beat_t exp_dat[$], obs_dat[$];
  int    exp_cnt[$], obs_cnt[$];
  bit    exp_last[$], obs_last[$];
  bit    timeout;
  int    first_lat;

  sparse_block_sequencer #(
    .IN_BLOCK_NUM (IN_BN), .BLOCK_SIZE (BS), .OUT_BLOCK_NUM (OUT_BN), .IN_WIDTH (W)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .data_in           (data_in),
    .data_in_zero_mask (data_in_zero_mask),
    .data_in_valid     (data_in_valid),
    .data_in_ready     (data_in_ready),
    .data_out          (data_out),
    .data_out_count    (data_out_count),
    .data_out_last     (data_out_last),
    .data_out_valid    (data_out_valid),
    .data_out_ready    (data_out_ready)
  );

  always #5 clk = ~clk;

  function automatic beat_t cur_beat();
    beat_t b;
    for (int j = 0; j < NO; j++) b[j] = data_out[j];
    return b;
  endfunction

  // Reference: list the non-zero block indices in order, then cut that list into
  // groups of OUT_BN; an empty list still yields one empty, final beat.
  function automatic void build_model(input logic [IN_BN-1:0] m);
    int    nz[$];
    beat_t bt;
    int    c;
    exp_dat.delete(); exp_cnt.delete(); exp_last.delete();
    for (int b = 0; b < IN_BN; b++) if (!m[b]) nz.push_back(b);
    if (nz.size() == 0) begin
      exp_dat.push_back('0); exp_cnt.push_back(0); exp_last.push_back(1'b1);
    end
    for (int i = 0; i < nz.size(); i += OUT_BN) begin
      bt = '0; c = 0;
      for (int s = 0; s < OUT_BN; s++) begin
        if (i + s < nz.size()) begin
          for (int e = 0; e < BS; e++) bt[s*BS+e] = data_in[nz[i+s]*BS+e];
          c++;
        end
      end
      exp_dat.push_back(bt); exp_cnt.push_back(c); exp_last.push_back(i + OUT_BN >= nz.size());
    end
  endfunction

  function automatic void ramp_data();
    for (int k = 0; k < NI; k++) data_in[k] = W'(k + 1);
  endfunction

  // Offers a frame and returns 1 time unit after the accepting clock edge.
  task automatic send(input logic [IN_BN-1:0] m);
    int n;
    @(negedge clk);
    data_in_zero_mask = m;
    data_in_valid     = 1'b1;
    n = 0;
    while (!data_in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      $display("FAIL send_timeout: data_in_ready stayed %b, required 1", data_in_ready);
      $fatal(1, "input never accepted");
    end
    @(posedge clk);
    #1 data_in_valid = 1'b0;
  endtask

  // Collects handshaken beats up to and including the last one.
  task automatic capture(input int rdy_pct);
    bit done;
    int n;
    obs_dat.delete(); obs_cnt.delete(); obs_last.delete();
    done = 0; n = 0; first_lat = -1; timeout = 0;
    while (!done && n < 200) begin
      @(negedge clk);
      n++;
      if (data_out_valid && first_lat < 0) first_lat = n;
      data_out_ready = ($urandom_range(99) < rdy_pct);
      if (data_out_valid && data_out_ready) begin
        obs_dat.push_back(cur_beat());
        obs_cnt.push_back(int'(data_out_count));
        obs_last.push_back(data_out_last);
        if (data_out_last) done = 1;
      end
    end
    if (!done) timeout = 1;
    @(posedge clk);
    #1 data_out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; data_in_valid = 1'b0; data_out_ready = 1'b0; data_in_zero_mask = '1;
    ramp_data();
    repeat (2) @(negedge clk);
    tests++; if (data_out_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", data_out_valid); end
    tests++; if (data_out_count !== 2'd0) begin fails++; $display("FAIL reset_count: got %0d want 0", data_out_count); end
    tests++; if (data_out_last !== 1'b0) begin fails++; $display("FAIL reset_last: got %b want 0", data_out_last); end
    tests++; if (cur_beat() !== '0) begin fails++; $display("FAIL reset_data: got %h want 0", cur_beat()); end
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    tests++; if (data_in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %b want 1", data_in_ready); end
  endtask

  task automatic test_directed();
    logic [IN_BN-1:0] masks [3];
    masks[0] = 4'b0000; masks[1] = 4'b1010; masks[2] = 4'b0111;
    for (int t = 0; t < 3; t++) begin
      ramp_data();
      build_model(masks[t]);
      send(masks[t]);
      capture(100);
      tests++; if (timeout) begin fails++; $display("FAIL dir_timeout mask=%b: no last beat, required one", masks[t]); end
      tests++; if (first_lat !== 1) begin fails++; $display("FAIL dir_latency mask=%b: got %0d want 1", masks[t], first_lat); end
      tests++;
      if (obs_dat.size() != exp_dat.size()) begin
        fails++; $display("FAIL dir_beats mask=%b: got %0d want %0d", masks[t], obs_dat.size(), exp_dat.size());
      end else begin
        for (int i = 0; i < exp_dat.size(); i++) begin
          tests++; if (obs_dat[i] !== exp_dat[i]) begin fails++; $display("FAIL dir_data mask=%b beat%0d: got %h want %h", masks[t], i, obs_dat[i], exp_dat[i]); end
          tests++; if (obs_cnt[i] !== exp_cnt[i]) begin fails++; $display("FAIL dir_count mask=%b beat%0d: got %0d want %0d", masks[t], i, obs_cnt[i], exp_cnt[i]); end
          tests++; if (obs_last[i] !== exp_last[i]) begin fails++; $display("FAIL dir_last mask=%b beat%0d: got %b want %b", masks[t], i, obs_last[i], exp_last[i]); end
        end
      end
    end
  endtask

  task automatic test_all_zero();
    ramp_data();
    send(4'b1111);
    data_out_ready = 1'b1;
    @(negedge clk);
    tests++; if (data_out_valid !== 1'b1) begin fails++; $display("FAIL zero_valid: got %b want 1", data_out_valid); end
    tests++; if (data_out_count !== 2'd0) begin fails++; $display("FAIL zero_count: got %0d want 0", data_out_count); end
    tests++; if (data_out_last !== 1'b1) begin fails++; $display("FAIL zero_last: got %b want 1", data_out_last); end
    tests++; if (cur_beat() !== '0) begin fails++; $display("FAIL zero_data: got %h want 0", cur_beat()); end
    tests++; if (data_in_ready !== 1'b0) begin fails++; $display("FAIL zero_in_ready_emit: got %b want 0", data_in_ready); end
    @(negedge clk);
    tests++; if (data_in_ready !== 1'b1) begin fails++; $display("FAIL zero_in_ready_after: got %b want 1", data_in_ready); end
    tests++; if (data_out_valid !== 1'b0) begin fails++; $display("FAIL zero_valid_after: got %b want 0", data_out_valid); end
    data_out_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    ramp_data();
    build_model(4'b0000);
    send(4'b0000);
    data_out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      tests++; if (data_out_valid !== 1'b1) begin fails++; $display("FAIL bp_valid cyc%0d: got %b want 1", c, data_out_valid); end
      tests++; if (cur_beat() !== exp_dat[0]) begin fails++; $display("FAIL bp_data cyc%0d: got %h want %h", c, cur_beat(), exp_dat[0]); end
      tests++; if (data_out_count !== 2'd2) begin fails++; $display("FAIL bp_count cyc%0d: got %0d want 2", c, data_out_count); end
      tests++; if (data_out_last !== 1'b0) begin fails++; $display("FAIL bp_last cyc%0d: got %b want 0", c, data_out_last); end
      tests++; if (data_in_ready !== 1'b0) begin fails++; $display("FAIL bp_in_ready cyc%0d: got %b want 0", c, data_in_ready); end
    end
    data_out_ready = 1'b1;
    @(negedge clk);
    tests++; if (cur_beat() !== exp_dat[1]) begin fails++; $display("FAIL bp_beat1_data: got %h want %h", cur_beat(), exp_dat[1]); end
    tests++; if (data_out_last !== 1'b1) begin fails++; $display("FAIL bp_beat1_last: got %b want 1", data_out_last); end
    @(negedge clk);
    tests++; if (data_out_valid !== 1'b0) begin fails++; $display("FAIL bp_done_valid: got %b want 0", data_out_valid); end
    data_out_ready = 1'b0;
  endtask

  task automatic test_reset_mid_emit();
    ramp_data();
    build_model(4'b0000);
    send(4'b0000);
    data_out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    tests++; if (cur_beat() !== exp_dat[1]) begin fails++; $display("FAIL rstmid_beat1: got %h want %h", cur_beat(), exp_dat[1]); end
    rst = 1'b1; data_out_ready = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    tests++; if (data_out_valid !== 1'b0) begin fails++; $display("FAIL rstmid_valid: got %b want 0", data_out_valid); end
    tests++; if (data_in_ready !== 1'b1) begin fails++; $display("FAIL rstmid_in_ready: got %b want 1", data_in_ready); end
    tests++; if (data_out_count !== 2'd0) begin fails++; $display("FAIL rstmid_count: got %0d want 0", data_out_count); end
    data_out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      tests++; if (data_out_valid !== 1'b0) begin fails++; $display("FAIL rstmid_no_beat cyc%0d: got %b want 0", c, data_out_valid); end
    end
    data_out_ready = 1'b0;
  endtask

  task automatic test_random();
    logic [IN_BN-1:0] m;
    for (int t = 0; t < 40; t++) begin
      for (int k = 0; k < NI; k++) data_in[k] = W'($urandom);
      m = IN_BN'($urandom);
      build_model(m);
      send(m);
      capture(int'($urandom_range(30, 100)));
      tests++; if (timeout) begin fails++; $display("FAIL rnd_timeout t%0d mask=%b: no last beat, required one", t, m); end
      tests++;
      if (obs_dat.size() != exp_dat.size()) begin
        fails++; $display("FAIL rnd_beats t%0d mask=%b: got %0d want %0d", t, m, obs_dat.size(), exp_dat.size());
      end else begin
        for (int i = 0; i < exp_dat.size(); i++) begin
          tests++; if (obs_dat[i] !== exp_dat[i]) begin fails++; $display("FAIL rnd_data t%0d beat%0d: got %h want %h", t, i, obs_dat[i], exp_dat[i]); end
          tests++; if (obs_cnt[i] !== exp_cnt[i]) begin fails++; $display("FAIL rnd_count t%0d beat%0d: got %0d want %0d", t, i, obs_cnt[i], exp_cnt[i]); end
          tests++; if (obs_last[i] !== exp_last[i]) begin fails++; $display("FAIL rnd_last t%0d beat%0d: got %b want %b", t, i, obs_last[i], exp_last[i]); end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_all_zero();
    test_backpressure();
    test_reset_mid_emit();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/sparse_block_sequencer.md
SPARSE_BLOCK_SEQUENCER -- requirements
Module: sparse_block_sequencer

Interface
REQ-001 SHALL have parameter IN_BLOCK_NUM, default 4: number of input blocks per beat.
REQ-002 SHALL have parameter BLOCK_SIZE, default 4: elements per block.
REQ-003 SHALL have parameter OUT_BLOCK_NUM, default 2: block slots per output beat; 1 <= OUT_BLOCK_NUM <= IN_BLOCK_NUM.
REQ-004 SHALL have parameter IN_WIDTH, default 16: element width in bits.
REQ-005 SHALL have port clk, input, 1: single clock; all logic on its rising edge.
REQ-006 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-007 SHALL have port data_in, input, IN_WIDTH x (IN_BLOCK_NUM*BLOCK_SIZE) unpacked: input elements; block b occupies elements b*BLOCK_SIZE to b*BLOCK_SIZE+BLOCK_SIZE-1.
REQ-008 SHALL have port data_in_zero_mask, input, IN_BLOCK_NUM: bit b = 1 marks block b as zero (skipped); 0 marks it non-zero.
REQ-009 SHALL have ports data_in_valid (input, 1) and data_in_ready (output, 1): input handshake.
REQ-010 SHALL have port data_out, output, IN_WIDTH x (OUT_BLOCK_NUM*BLOCK_SIZE) unpacked: compacted non-zero blocks.
REQ-011 SHALL have port data_out_count, output, $clog2(OUT_BLOCK_NUM+1): number of valid block slots in the current beat.
REQ-012 SHALL have port data_out_last, output, 1: final beat of the current input frame.
REQ-013 SHALL have ports data_out_valid (output, 1) and data_out_ready (input, 1): output handshake.

Function
REQ-014 SHALL implement FSM states IDLE and EMIT.
REQ-015 SHALL drive data_in_ready = 1 only in IDLE.
REQ-016 SHALL, on data_in_valid && data_in_ready, register data_in and the mask, then move to EMIT on the next cycle.
REQ-017 SHALL assert data_out_valid in the cycle after input acceptance; latency is 1 cycle.
REQ-018 SHALL, in each EMIT beat, place the lowest-indexed remaining non-zero blocks (up to OUT_BLOCK_NUM) into slots 0.. in ascending block order.
REQ-019 SHALL drive unused slots with zeros.
REQ-020 SHALL set data_out_count to the number of filled slots.
REQ-021 SHALL set data_out_last = 1 when no non-zero blocks remain after the current beat.
REQ-022 SHALL, on an output handshake, clear the emitted blocks from the remaining mask; if data_out_last was 1, return to IDLE, otherwise stay in EMIT.
REQ-023 SHALL, for an all-zero frame (mask all 1), emit exactly one beat with count 0, last 1 and data zeros.
REQ-024 SHALL, for a frame with N non-zero blocks, emit exactly max(1, ceil(N/OUT_BLOCK_NUM)) beats.
REQ-025 SHALL hold data_out, data_out_count and data_out_last stable while data_out_valid=1 and data_out_ready=0.
REQ-026 SHALL not accept new input in EMIT, including the cycle in which the last beat completes; the earliest next acceptance is the following cycle, in IDLE.
REQ-027 SHALL copy data values unmodified; no arithmetic is performed on them.

Reset
REQ-028 SHALL, while rst=1 at a clock edge, set state IDLE, data_out_valid 0, data_out_count 0, data_out_last 0, data_out all zeros and the remaining mask all 1; data_in_ready reads 1 from the cycle after reset.
REQ-029 SHALL let reset asserted mid-EMIT abandon the frame without emitting further beats.

Structure
REQ-030 SHALL define the state enum (IDLE, EMIT) in shared package sparse_arithmetic_pkg.
REQ-031 SHALL use one combinational sub-module, sparse_block_pick: from the remaining mask it returns up to OUT_BLOCK_NUM selected block indices, the selected count and the updated mask.
REQ-032 SHALL keep the datapath registers and FSM in sparse_block_sequencer.

Verification (defaults; data_in[k] = k+1)
REQ-033 SHALL cover: mask 4'b0000 -> beat0 data_out = 1..8, count 2, last 0; beat1 data_out = 9..16, count 2, last 1.
REQ-034 SHALL cover: mask 4'b1010 -> one beat, data_out = 1..4, 9..12, count 2, last 1.
REQ-035 SHALL cover: mask 4'b0111 -> one beat, data_out = 13..16 then zeros, count 1, last 1.
REQ-036 SHALL cover: mask 4'b1111 -> one beat, data zeros, count 0, last 1; data_in_ready = 1 two cycles after acceptance.
REQ-037 SHALL cover: mask 4'b0000 with data_out_ready held 0 for 5 cycles during beat0 -> outputs stable, data_in_ready 0, beat1 follows release.
REQ-038 SHALL cover: rst pulsed during beat1 of mask 4'b0000 -> next cycle data_out_valid 0, data_in_ready 1, no beat1 emitted.
